// File: rtl/obj_dma.sv
// Sprite DMA: on a DMA_ON rising edge, request the CPU bus, copy object RAM into the
// private sprite line buffer word-by-word once hold is acknowledged, then release the bus.
module obj_dma #(
  parameter int NUM_WORDS = 512,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16
) (
  input  logic              CLK_32M,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              dma_on,
  input  logic              hlda,
  output logic              brq,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd,
  input  logic [DATA_W-1:0] src_din,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              dst_we,
  output logic [DATA_W-1:0] dst_dout,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] LAST_RD = (ADDR_W+1)'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_COPY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_dma_prev;
  logic [ADDR_W:0]     r_rd;
  logic                r_dst_we;
  logic [ADDR_W-1:0]   r_dst_addr;
  logic                w_trig;
  logic                w_last;

  assign w_trig   = dma_on & ~r_dma_prev;
  assign w_last   = (r_rd == LAST_RD);
  assign src_addr = r_rd[ADDR_W-1:0];
  assign dst_addr = r_dst_addr;
  assign dst_we   = r_dst_we;

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_trig) w_state_nxt = S_REQ;
      S_REQ:   if (hlda) w_state_nxt = S_COPY;
      S_COPY:  if (hlda && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reads are gated by hlda in the same cycle so the object RAM is never touched without the grant.
  always_comb begin
    brq    = (r_state == S_REQ) || (r_state == S_COPY) || (r_state == S_DRAIN);
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
    src_rd = (r_state == S_COPY) && hlda;
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      r_dma_prev <= 1'b0;
      r_rd       <= '0;
      r_dst_we   <= 1'b0;
      r_dst_addr <= '0;
    end else if (ce) begin
      r_dma_prev <= dma_on;
      if (r_state == S_REQ) begin
        r_rd <= '0;
      end else if (src_rd) begin
        r_rd <= r_rd + (ADDR_W+1)'(1);
      end
      r_dst_we   <= src_rd;
      r_dst_addr <= src_addr;
    end
  end

  // Object RAM data arrives one ce-cycle after the read, aligned with the registered write strobe.
  always_comb begin
    dst_dout = r_dst_we ? src_din : '0;
  end

endmodule

// File: tb/tb_obj_dma.sv
// Scoreboard bench for obj_dma: stimulus pushes expected writes and done timing,
// a negedge monitor pops and compares whenever the DUT writes or signals done.
module tb_obj_dma;

  localparam int NW = 512;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic        dma_on;
  logic        hlda;
  logic        brq;
  logic [8:0]  src_addr;
  logic        src_rd;
  logic [15:0] src_din;
  logic [8:0]  dst_addr;
  logic        dst_we;
  logic [15:0] dst_dout;
  logic        busy;
  logic        done;

  logic [15:0] obj_ram [NW];
  logic [15:0] sbuf [NW];
  logic [15:0] ram_q;
  logic [15:0] pat;

  wr_t  wq[$];
  int   dq[$];
  int   n_checks;
  int   n_fail;
  int   ce_cnt;
  int   trig_base;
  int   exp_rd;
  int   n_writes;
  int   n_reads;
  int   div;

  obj_dma #(.NUM_WORDS(512), .ADDR_W(9), .DATA_W(16)) dut (
    .CLK_32M (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .dma_on  (dma_on),
    .hlda    (hlda),
    .brq     (brq),
    .src_addr(src_addr),
    .src_rd  (src_rd),
    .src_din (src_din),
    .dst_addr(dst_addr),
    .dst_we  (dst_we),
    .dst_dout(dst_dout),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ce changes 1 time unit after the edge; stimulus changes 2 units after it.
  initial begin
    int cnt;
    cnt = 0;
    ce  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1 >= div) ? 0 : cnt + 1;
      ce  = (cnt == 0);
    end
  end

  initial ce_cnt = 0;
  always @(posedge clk) if (ce) ce_cnt <= ce_cnt + 1;

  // Object RAM: synchronous read, data valid in the ce-cycle after src_rd.
  always @(posedge clk) if (ce && src_rd) ram_q <= obj_ram[src_addr];
  assign src_din = ram_q;

  always @(posedge clk) if (ce && dst_we) sbuf[dst_addr] <= dst_dout;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n && ce) begin
      if (dst_we) begin
        n_writes++;
        if (wq.size() == 0) begin
          chk("unexpected_write", 32'(dst_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", 32'(dst_addr), 32'(e.addr));
          chk("wr_data", 32'(dst_dout), 32'(e.data));
        end
      end
      if (src_rd) begin
        n_reads++;
        chk("rd_grant", 32'(hlda), 32'd1);
        chk("rd_addr", 32'(src_addr), 32'(exp_rd));
        exp_rd++;
      end
      if (done) begin
        chk("done_brq", 32'(brq), 32'd0);
        if (dq.size() == 0) chk("unexpected_done", 32'(ce_cnt - trig_base), 32'hFFFF_FFFF);
        else chk("done_cycle", 32'(ce_cnt - trig_base), 32'(dq.pop_front()));
      end
    end
  end

  task automatic wait_ce_edge();
    do @(posedge clk); while (!ce);
    #2;
  endtask

  task automatic load_ram(input logic [15:0] p);
    pat = p;
    for (int i = 0; i < NW; i++) obj_ram[i] = 16'(i) ^ p;
  endtask

  task automatic start_xfer(input int done_rel, input int hold);
    for (int i = 0; i < NW; i++) begin
      wr_t e;
      e.addr = 9'(i);
      e.data = 16'(i) ^ pat;
      wq.push_back(e);
    end
    dq.push_back(done_rel);
    exp_rd   = 0;
    n_writes = 0;
    n_reads  = 0;
    wait_ce_edge();
    dma_on    = 1'b1;
    trig_base = ce_cnt;
    repeat (hold) wait_ce_edge();
    dma_on = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (ce_cnt - trig_base < n) wait_ce_edge();
  endtask

  task automatic pulse();
    dma_on = 1'b1;
    wait_ce_edge();
    dma_on = 1'b0;
  endtask

  task automatic finish_xfer(input string nm);
    int ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy && wq.size() == 0 && dq.size() == 0) begin
        ok = 1;
        break;
      end
      wait_ce_edge();
    end
    if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
    chk({nm, "_writes"}, 32'(n_writes), 32'(NW));
    chk({nm, "_reads"}, 32'(n_reads), 32'(NW));
  endtask

  task automatic check_buffer(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < NW; i++) if (sbuf[i] !== (16'(i) ^ pat)) bad++;
    chk({nm, "_buffer_bad_words"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    div      = 1;
    reset_n  = 1'b0;
    dma_on   = 1'b0;
    hlda     = 1'b0;
    exp_rd   = 0;
    load_ram(16'hA5A5);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_brq", 32'(brq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_src_rd", 32'(src_rd), 32'd0);
    chk("rst_dst_we", 32'(dst_we), 32'd0);
    chk("rst_src_addr", 32'(src_addr), 32'd0);
    chk("rst_dst_addr", 32'(dst_addr), 32'd0);
    chk("rst_dst_dout", 32'(dst_dout), 32'd0);
    reset_n = 1'b1;
    repeat (4) wait_ce_edge();

    // hlda high while idle must not start anything
    hlda = 1'b1;
    repeat (10) wait_ce_edge();
    chk("idle_hlda_busy", 32'(busy), 32'd0);
    chk("idle_hlda_brq", 32'(brq), 32'd0);

    // basic copy
    start_xfer(515, 1);
    chk("basic_brq_req", 32'(brq), 32'd1);
    chk("basic_busy_req", 32'(busy), 32'd1);
    finish_xfer("basic");
    check_buffer("basic");
    chk("basic_brq_after", 32'(brq), 32'd0);

    // grant delayed 20 ce-cycles after brq
    hlda = 1'b0;
    load_ram(16'h1234);
    start_xfer(535, 1);
    wait_rel(21);
    chk("delay_no_read_before_grant", 32'(n_reads), 32'd0);
    hlda = 1'b1;
    finish_xfer("delay");
    check_buffer("delay");

    // hlda dropped for 7 ce-cycles after word 300 is issued
    load_ram(16'h0F0F);
    start_xfer(522, 1);
    begin
      int found;
      found = 0;
      for (int i = 0; i < 700; i++) begin
        wait_ce_edge();
        if (src_rd && src_addr == 9'd300) begin
          found = 1;
          break;
        end
      end
      if (!found) chk("stall_find_300", 32'd0, 32'd1);
    end
    wait_ce_edge();
    hlda = 1'b0;
    repeat (7) wait_ce_edge();
    chk("stall_brq_held", 32'(brq), 32'd1);
    hlda = 1'b1;
    finish_xfer("stall");
    check_buffer("stall");

    // retriggers during COPY and in the DONE cycle are ignored
    load_ram(16'hA5A5);
    start_xfer(515, 1);
    wait_rel(50);
    pulse();
    wait_rel(513);
    pulse();
    wait_rel(515);
    pulse();
    finish_xfer("retrig");
    repeat (30) wait_ce_edge();
    chk("retrig_no_restart", 32'(busy), 32'd0);
    chk("retrig_extra_writes", 32'(n_writes), 32'(NW));

    // dma_on held high for 40 ce-cycles gives one transfer
    start_xfer(515, 40);
    finish_xfer("hold");
    repeat (30) wait_ce_edge();
    chk("hold_no_restart", 32'(busy), 32'd0);

    // asynchronous reset at word 100
    start_xfer(515, 1);
    begin
      int found;
      found = 0;
      for (int i = 0; i < 300; i++) begin
        wait_ce_edge();
        if (src_rd && src_addr == 9'd100) begin
          found = 1;
          break;
        end
      end
      if (!found) chk("reset_find_100", 32'd0, 32'd1);
    end
    reset_n = 1'b0;
    #1;
    chk("reset_brq_async", 32'(brq), 32'd0);
    chk("reset_dst_we_async", 32'(dst_we), 32'd0);
    chk("reset_busy_async", 32'(busy), 32'd0);
    chk("reset_src_rd_async", 32'(src_rd), 32'd0);
    wq.delete();
    dq.delete();
    repeat (2) wait_ce_edge();
    reset_n  = 1'b1;
    n_writes = 0;
    repeat (30) wait_ce_edge();
    chk("reset_no_writes_after", 32'(n_writes), 32'd0);
    chk("reset_idle", 32'(busy), 32'd0);

    // ce active every 4th clock
    div = 4;
    load_ram(16'h3C3C);
    repeat (4) wait_ce_edge();
    start_xfer(515, 1);
    finish_xfer("ce4");
    check_buffer("ce4");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
